// File: rtl/smartflow_pkg.sv
// Shared types and timing defaults for the smartFlow intersection controller.
package smartflow_pkg;

   typedef enum logic [2:0] {
      StNGreen  = 3'd0,
      StNYellow = 3'd1,
      StRed1    = 3'd2,
      StEGreen  = 3'd3,
      StEYellow = 3'd4,
      StRed2    = 3'd5
   } state_e;

   localparam int unsigned GreenBaseDef  = 4;
   localparam int unsigned GreenStepDef  = 2;
   localparam int unsigned YellowTimeDef = 2;
   localparam int unsigned AllredTimeDef = 1;
   localparam int unsigned MaxDensity    = 3;

   // Bits needed to hold (max_dur - 1); never below one bit.
   function automatic int unsigned dur_width(input int unsigned max_dur);
      return (max_dur <= 2) ? 1 : $clog2(max_dur);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   localparam int unsigned DurW =
      dur_width(max3(GreenBaseDef + MaxDensity * GreenStepDef, YellowTimeDef, AllredTimeDef));

endpackage

// File: rtl/smartflow_phase_timer.sv
// Loadable down-counter for phase durations; expired flags a count of zero.
module phase_timer #(
   parameter int unsigned Width      = 4,
   parameter int unsigned ResetValue = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [Width-1:0] load_value,
   output logic             expired
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= Width'(ResetValue);
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/smartflow_top.sv
// Adaptive two-way traffic-light controller with density-scaled green phases.
// Optional build macro SMARTFLOW_HOLD_EN: hold green while opposing demand is zero.
module smartflow_top
   import smartflow_pkg::*;
#(
   parameter int unsigned GREEN_BASE  = GreenBaseDef,
   parameter int unsigned GREEN_STEP  = GreenStepDef,
   parameter int unsigned YELLOW_TIME = YellowTimeDef,
   parameter int unsigned ALLRED_TIME = AllredTimeDef
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sensor_N,
   input  logic [1:0] sensor_E,
   output logic       green_N,
   output logic       yellow_N,
   output logic       red_N,
   output logic       green_E,
   output logic       yellow_E,
   output logic       red_E
);

   localparam int unsigned TimerW =
      dur_width(max3(GREEN_BASE + MaxDensity * GREEN_STEP, YELLOW_TIME, ALLRED_TIME));
   localparam logic [TimerW-1:0] YellowM1 = TimerW'(YELLOW_TIME - 1);
   localparam logic [TimerW-1:0] AllredM1 = TimerW'(ALLRED_TIME - 1);

   state_e            state_q, state_d;
   logic              load, expired;
   logic [TimerW-1:0] load_value;
   logic [TimerW-1:0] green_n_m1, green_e_m1;

   assign green_n_m1 = TimerW'(GREEN_BASE - 1) + TimerW'(GREEN_STEP) * TimerW'(sensor_N);
   assign green_e_m1 = TimerW'(GREEN_BASE - 1) + TimerW'(GREEN_STEP) * TimerW'(sensor_E);

   phase_timer #(
      .Width      (TimerW),
      .ResetValue (GREEN_BASE - 1)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .expired    (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StNGreen;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      load_value = '0;
      if (expired) begin
         load = 1'b1;
         unique case (state_q)
            StNGreen: begin
`ifdef SMARTFLOW_HOLD_EN
               if (sensor_E == 2'd0) begin
                  state_d    = StNGreen;
                  load_value = green_n_m1;
               end else begin
                  state_d    = StNYellow;
                  load_value = YellowM1;
               end
`else
               state_d    = StNYellow;
               load_value = YellowM1;
`endif
            end
            StNYellow: begin
               state_d    = StRed1;
               load_value = AllredM1;
            end
            StRed1: begin
               state_d    = StEGreen;
               load_value = green_e_m1;
            end
            StEGreen: begin
`ifdef SMARTFLOW_HOLD_EN
               if (sensor_N == 2'd0) begin
                  state_d    = StEGreen;
                  load_value = green_e_m1;
               end else begin
                  state_d    = StEYellow;
                  load_value = YellowM1;
               end
`else
               state_d    = StEYellow;
               load_value = YellowM1;
`endif
            end
            StEYellow: begin
               state_d    = StRed2;
               load_value = AllredM1;
            end
            StRed2: begin
               state_d    = StNGreen;
               load_value = green_n_m1;
            end
            default: begin
               state_d    = StNGreen;
               load_value = green_n_m1;
            end
         endcase
      end
   end

   always_comb begin
      green_N  = 1'b0;
      yellow_N = 1'b0;
      red_N    = 1'b0;
      green_E  = 1'b0;
      yellow_E = 1'b0;
      red_E    = 1'b0;
      unique case (state_q)
         StNGreen:  begin green_N  = 1'b1; red_E = 1'b1; end
         StNYellow: begin yellow_N = 1'b1; red_E = 1'b1; end
         StEGreen:  begin green_E  = 1'b1; red_N = 1'b1; end
         StEYellow: begin yellow_E = 1'b1; red_N = 1'b1; end
         default:   begin red_N    = 1'b1; red_E = 1'b1; end
      endcase
   end

endmodule

// File: tb/tb_smartflow_top.sv
// Directed self-checking bench for smartflow_top; phase lengths checked cycle by cycle.
// With SMARTFLOW_HOLD_EN defined the reset test is replaced by the hold test.
module tb_smartflow_top;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] sensor_N, sensor_E;
   logic       green_N, yellow_N, red_N, green_E, yellow_E, red_E;
   logic [5:0] lights;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [5:0] PatNg = 6'b100_001;
   localparam logic [5:0] PatNy = 6'b010_001;
   localparam logic [5:0] PatRr = 6'b001_001;
   localparam logic [5:0] PatEg = 6'b001_100;
   localparam logic [5:0] PatEy = 6'b001_010;

   smartflow_top dut (
      .clk      (clk),
      .reset    (reset),
      .sensor_N (sensor_N),
      .sensor_E (sensor_E),
      .green_N  (green_N),
      .yellow_N (yellow_N),
      .red_N    (red_N),
      .green_E  (green_E),
      .yellow_E (yellow_E),
      .red_E    (red_E)
   );

   always #5 clk = ~clk;

   assign lights = {green_N, yellow_N, red_N, green_E, yellow_E, red_E};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a negedge; checks the pattern for len cycles, returns at the next phase's negedge.
   task automatic expect_phase(input string tag, input logic [5:0] pat, input int len);
      for (int i = 0; i < len; i++) begin
         check(tag, {2'b00, lights}, {2'b00, pat});
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   initial begin
      reset    = 1'b1;
      sensor_N = 2'd0;
      sensor_E = 2'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_lights", {2'b00, lights}, {2'b00, PatNg});

`ifdef SMARTFLOW_HOLD_EN
      sensor_N = 2'd2;
      reset    = 1'b0;
      // 4 + 8 + 8 + 8 + 2 cycles of continuous N green under zero E demand
      expect_phase("hold_ng", PatNg, 30);
      sensor_E = 2'd1;
      expect_phase("hold_ng_tail", PatNg, 6);
      expect_phase("hold_ny", PatNy, 2);
      expect_phase("hold_r1", PatRr, 1);
      expect_phase("hold_eg", PatEg, 6);
      expect_phase("hold_ey", PatEy, 2);
`else
      reset = 1'b0;
      expect_phase("rst_ng", PatNg, 4);
      expect_phase("rst_ny", PatNy, 2);
      expect_phase("rst_r1", PatRr, 1);
      expect_phase("rst_eg", PatEg, 4);
      expect_phase("rst_ey", PatEy, 2);
`endif

      // Density scaling: N=3 -> 10 cycles, E=1 -> 6 cycles
      sensor_N = 2'd3;
      sensor_E = 2'd1;
      expect_phase("dens_r2", PatRr, 1);
      expect_phase("dens_ng", PatNg, 10);
      expect_phase("dens_ny", PatNy, 2);
      expect_phase("dens_r1", PatRr, 1);
      expect_phase("dens_eg", PatEg, 6);
      expect_phase("dens_ey", PatEy, 2);
      expect_phase("dens_r2b", PatRr, 1);

      // Swap mid-green: running N green keeps its 10 cycles
      expect_phase("swap_ng_a", PatNg, 5);
      sensor_N = 2'd1;
      sensor_E = 2'd3;
      expect_phase("swap_ng_b", PatNg, 5);
      expect_phase("swap_ny", PatNy, 2);
      expect_phase("swap_r1", PatRr, 1);
      expect_phase("swap_eg", PatEg, 10);
      expect_phase("swap_ey", PatEy, 2);
      expect_phase("swap_r2", PatRr, 1);
      expect_phase("swap_ng", PatNg, 6);
      expect_phase("swap_ny2", PatNy, 2);
      expect_phase("swap_r1b", PatRr, 1);
      expect_phase("swap_eg2", PatEg, 10);

      // Mid-phase reset in the first E_YELLOW cycle
      check("mid_ey", {2'b00, lights}, {2'b00, PatEy});
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      expect_phase("mrst_ng", PatNg, 4);
      expect_phase("mrst_ny", PatNy, 2);

      // Safety sweep with random sensors
      for (int c = 0; c < 500; c++) begin
         sensor_N = 2'($urandom_range(0, 3));
         sensor_E = 2'($urandom_range(0, 3));
         check("safe_onehot_n", {7'd0, $onehot({green_N, yellow_N, red_N})}, 8'd1);
         check("safe_onehot_e", {7'd0, $onehot({green_E, yellow_E, red_E})}, 8'd1);
         check("safe_conflict", {7'd0, (green_N | yellow_N) & (green_E | yellow_E)}, 8'd0);
         @(posedge clk);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
